// File: rtl/grid_board_drawer.sv
// Draws one of BOARDS square-cell game grids into the VGA frame buffer, one pixel per cycle:
// either a whole board (grid lines plus fill) or the interior of a single cell.
module grid_board_drawer #(
  parameter int ORIGIN_X      = 4,
  parameter int ORIGIN_Y      = 90,
  parameter int CELL          = 12,
  parameter int GAP           = 2,
  parameter int COLS          = 10,
  parameter int ROWS          = 10,
  parameter int BOARDS        = 2,
  parameter int BOARD_SPACING = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic [1:0] board_sel,
  input  logic [3:0] cell_col,
  input  logic [3:0] cell_row,
  input  logic [2:0] fill_colour,
  input  logic [2:0] grid_colour,
  output logic       busy,
  output logic       done,
  output logic       done_err,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  localparam int P      = CELL + GAP;
  localparam int W      = COLS * P + GAP;
  localparam int H      = ROWS * P + GAP;
  localparam int STRIDE = W + BOARD_SPACING;
  localparam int LAST_X = ORIGIN_X + (BOARDS - 1) * STRIDE + W - 1;
  localparam int LAST_Y = ORIGIN_Y + H - 1;

  localparam logic [8:0] GAP_X    = 9'(GAP);
  localparam logic [7:0] GAP_Y    = 8'(GAP);
  localparam logic [8:0] PM1_X    = 9'(P - 1);
  localparam logic [7:0] PM1_Y    = 8'(P - 1);
  localparam logic [8:0] W_LAST   = 9'(W - 1);
  localparam logic [7:0] H_LAST   = 8'(H - 1);
  localparam logic [8:0] CELL_LX  = 9'(CELL - 1);
  localparam logic [7:0] CELL_LY  = 8'(CELL - 1);

  generate
    if (LAST_X > 319 || LAST_Y > 239) begin : g_geometry_check
      $fatal(1, "grid_board_drawer: board geometry exceeds the 320x240 frame");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t     state, state_d;
  logic       mode_q, mode_d;
  logic [2:0] fill_q, fill_d, grid_q, grid_d;
  logic [8:0] base_x, base_x_d, span_lx, span_lx_d, cnt_x, cnt_x_d, mod_x, mod_x_d;
  logic [7:0] base_y, base_y_d, span_ly, span_ly_d, cnt_y, cnt_y_d, mod_y, mod_y_d;
  logic       last_q, last_d, err_q, err_d;
  logic       busy_d, done_d, done_err_d, plot_d;
  logic [8:0] vga_x_d;
  logic [7:0] vga_y_d;
  logic [2:0] colour_d;
  logic       req_bad;

  // mod_x/mod_y track (lx mod P, ly mod P) so grid lines need no divider
  always_comb begin
    state_d    = state;
    mode_d     = mode_q;
    fill_d     = fill_q;
    grid_d     = grid_q;
    base_x_d   = base_x;
    base_y_d   = base_y;
    span_lx_d  = span_lx;
    span_ly_d  = span_ly;
    cnt_x_d    = cnt_x;
    cnt_y_d    = cnt_y;
    mod_x_d    = mod_x;
    mod_y_d    = mod_y;
    last_d     = last_q;
    err_d      = err_q;
    busy_d     = busy;
    done_d     = done;
    done_err_d = done_err;
    plot_d     = 1'b0;
    vga_x_d    = vga_x;
    vga_y_d    = vga_y;
    colour_d   = vga_colour;
    req_bad    = (int'(board_sel) >= BOARDS) ||
                 (mode && ((int'(cell_col) >= COLS) || (int'(cell_row) >= ROWS)));

    case (state)
      IDLE: begin
        busy_d     = 1'b0;
        done_d     = 1'b0;
        done_err_d = 1'b0;
        if (start) begin
          mode_d    = mode;
          fill_d    = fill_colour;
          grid_d    = grid_colour;
          base_x_d  = 9'(ORIGIN_X + int'(board_sel) * STRIDE +
                         (mode ? GAP + int'(cell_col) * P : 0));
          base_y_d  = 8'(ORIGIN_Y + (mode ? GAP + int'(cell_row) * P : 0));
          span_lx_d = mode ? CELL_LX : W_LAST;
          span_ly_d = mode ? CELL_LY : H_LAST;
          cnt_x_d   = '0;
          cnt_y_d   = '0;
          mod_x_d   = '0;
          mod_y_d   = '0;
          last_d    = 1'b0;
          err_d     = req_bad;
          if (req_bad) begin
            state_d = DONE;
          end else begin
            busy_d  = 1'b1;
            state_d = SCAN;
          end
        end
      end

      SCAN: begin
        if (!start) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (last_q) begin
          busy_d     = 1'b0;
          done_d     = 1'b1;
          done_err_d = 1'b0;
          state_d    = DONE;
        end else begin
          plot_d   = 1'b1;
          vga_x_d  = base_x + cnt_x;
          vga_y_d  = base_y + cnt_y;
          colour_d = (!mode_q && (mod_x < GAP_X || mod_y < GAP_Y)) ? grid_q : fill_q;
          if (cnt_x == span_lx) begin
            cnt_x_d = '0;
            mod_x_d = '0;
            if (cnt_y == span_ly) begin
              last_d = 1'b1;
            end else begin
              cnt_y_d = cnt_y + 8'd1;
              mod_y_d = (mod_y == PM1_Y) ? '0 : mod_y + 8'd1;
            end
          end else begin
            cnt_x_d = cnt_x + 9'd1;
            mod_x_d = (mod_x == PM1_X) ? '0 : mod_x + 9'd1;
          end
        end
      end

      DONE: begin
        if (start) begin
          done_d     = 1'b1;
          done_err_d = err_q;
        end else begin
          done_d     = 1'b0;
          done_err_d = 1'b0;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      fill_q     <= '0;
      grid_q     <= '0;
      base_x     <= '0;
      base_y     <= '0;
      span_lx    <= '0;
      span_ly    <= '0;
      cnt_x      <= '0;
      cnt_y      <= '0;
      mod_x      <= '0;
      mod_y      <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      done_err   <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      state      <= state_d;
      mode_q     <= mode_d;
      fill_q     <= fill_d;
      grid_q     <= grid_d;
      base_x     <= base_x_d;
      base_y     <= base_y_d;
      span_lx    <= span_lx_d;
      span_ly    <= span_ly_d;
      cnt_x      <= cnt_x_d;
      cnt_y      <= cnt_y_d;
      mod_x      <= mod_x_d;
      mod_y      <= mod_y_d;
      last_q     <= last_d;
      err_q      <= err_d;
      busy       <= busy_d;
      done       <= done_d;
      done_err   <= done_err_d;
      vga_plot   <= plot_d;
      vga_x      <= vga_x_d;
      vga_y      <= vga_y_d;
      vga_colour <= colour_d;
    end
  end

endmodule
